// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  localparam int BCD_W = 4;

  // One-hot select for up to 8 digits; an index at or beyond n yields all zeros.
  function automatic logic [7:0] onehot(input logic [2:0] idx, input int n);
    logic [7:0] r;
    r = '0;
    if (int'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_phase_cnt.sv
// Loadable down-counter timing the BLANK and SHOW phases; tc_o flags the last cycle of a phase.
module seg7_phase_cnt #(
  parameter int W       = 4,
  parameter int RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (load_i) cnt_d = load_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= W'(RST_VAL);
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS BCD nibbles onto a shared decoder with a blanking gap before each
// digit; new display values take effect only at the frame wrap.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  output logic [BCD_W-1:0]            dig_code,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int VW   = BCD_W * NUM_DIGITS;
  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  state_e                  state_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [VW-1:0]           active_q, active_d;
  logic [VW-1:0]           pending_q;
  logic                    pending_valid_q;
  logic [BCD_W-1:0]        dig_code_q, nib_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q;
  logic [7:0]              en_full;
  logic                    tc, wrap;
  logic [CW-1:0]           cnt_load_val;

  // The counter holds remaining cycles; its reset value equals an elapsed count of zero.
  seg7_phase_cnt #(.W(CW), .RST_VAL(BLANK_CYCLES - 1)) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tc),
    .load_val_i (cnt_load_val),
    .tc_o       (tc)
  );

  assign cnt_load_val = (state_q == ST_BLANK) ? CW'(PRESCALE - 1) : CW'(BLANK_CYCLES - 1);
  assign wrap = (state_q == ST_SHOW) && tc && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    active_d = active_q;
    if (wrap) begin
      if (load)                 active_d = value_in;
      else if (pending_valid_q) active_d = pending_q;
    end
    idx_d = idx_q;
    if (state_q == ST_SHOW && tc) idx_d = wrap ? '0 : IW'(idx_q + 1'b1);
    nib_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IW'(i)) nib_d = active_d[i*BCD_W +: BCD_W];
    en_full    = onehot(3'(idx_q), NUM_DIGITS) & ~8'(blank_mask);
    digit_en_d = NUM_DIGITS'(en_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_BLANK;
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      dig_code_q      <= '0;
      digit_en_q      <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      active_q     <= active_d;
      if (wrap) begin
        pending_valid_q <= 1'b0;
      end else if (load) begin
        pending_q       <= value_in;
        pending_valid_q <= 1'b1;
      end
      case (state_q)
        ST_BLANK: begin
          digit_en_q <= '0;
          if (tc) begin
            state_q    <= ST_SHOW;
            digit_en_q <= digit_en_d;
          end
        end
        default: begin
          digit_en_q <= digit_en_d;
          if (tc) begin
            state_q    <= ST_BLANK;
            idx_q      <= idx_d;
            digit_en_q <= '0;
            dig_code_q <= nib_d;
          end
        end
      endcase
    end
  end

  assign dig_code   = dig_code_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
